vending_credit_fsm: RTL and testbench

Parametrised successor to the fixed-price 5/10 vending controller. It accumulates coin credit in 5-unit steps toward a configurable price and accepts a third coin denomination (25). Overpayment of any size is returned as a serial train of `chg5` pulses, with the block busy while change is paid out. It sits between the coin-acceptor decode and the dispense/change actuators.

---
 rtl/vending_credit_fsm.sv | 93 +++++++++
 tb/tb_vending_credit_fsm.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/vending_credit_fsm.sv
// Coin-credit vending controller: collects 5/10/25 coins toward PRICE and pays change as chg5 pulses.
// Optional refund path on cancel is built when VEND_CANCEL_EN is defined.
module vending_credit_fsm #(
  parameter int PRICE = 4,
  parameter int CW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    coin,
  input  logic          cancel,
  output logic          vend,
  output logic          chg5,
  output logic          busy,
  output logic [CW-1:0] credit
);

  typedef enum logic {COLLECT = 1'b0, CHANGE = 1'b1} state_t;

  localparam logic [CW-1:0] PRICE_C = CW'(PRICE);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] coin_val;
  logic [CW-1:0] sum;
  logic          cancel_req;

  always_comb begin
    coin_val = '0;
    case (coin)
      2'b01:   coin_val = CW'(1);
      2'b10:   coin_val = CW'(2);
      2'b11:   coin_val = CW'(5);
      default: coin_val = '0;
    endcase
  end

  // Parameter rule 2^CW > PRICE + 4 keeps this sum from wrapping.
  assign sum = cnt + coin_val;

`ifdef VEND_CANCEL_EN
  assign cancel_req = cancel;
`else
  assign cancel_req = 1'b0;
  logic unused_cancel;
  assign unused_cancel = cancel;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= COLLECT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    vend      = 1'b0;
    chg5      = 1'b0;
    busy      = 1'b0;
    case (state)
      COLLECT: begin
        if (sum >= PRICE_C) begin
          // vend is Mealy; gate with reset so it stays low while reset is held.
          vend    = reset;
          cnt_nxt = sum - PRICE_C;
          if (sum != PRICE_C) state_nxt = CHANGE;
        end else if (cancel_req && (sum != '0)) begin
          cnt_nxt   = sum;
          state_nxt = CHANGE;
        end else begin
          cnt_nxt = sum;
        end
      end
      CHANGE: begin
        chg5    = 1'b1;
        busy    = 1'b1;
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) state_nxt = COLLECT;
      end
      default: begin
        state_nxt = COLLECT;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign credit = cnt;

endmodule

// File: tb/tb_vending_credit_fsm.sv
// Randomised and directed bench for vending_credit_fsm with a queue-based scoreboard
// fed by an integer-arithmetic model of credit and outstanding change.
module tb_vending_credit_fsm;
  localparam int PRICE = 4;
  localparam int CW    = 5;
  localparam int W     = CW + 3;
`ifdef VEND_CANCEL_EN
  localparam bit CANCEL_EN = 1'b1;
`else
  localparam bit CANCEL_EN = 1'b0;
`endif

  logic          clk, clk_en, reset, cancel, vend, chg5, busy;
  logic [1:0]    coin;
  logic [CW-1:0] credit;

  vending_credit_fsm #(.PRICE(PRICE), .CW(CW)) dut (
    .clk(clk), .reset(reset), .coin(coin), .cancel(cancel),
    .vend(vend), .chg5(chg5), .busy(busy), .credit(credit)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  bit mon_en = 1'b0;

  // reference model state: banked credit and units of change still owed
  int m_credit = 0;
  int m_change = 0;

  function automatic int coin_units(input logic [1:0] c);
    case (c)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 5;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s {vend,chg5,busy,credit} got %b_%b_%b_%0d required %b_%b_%b_%0d", name,
               got[W-1], got[W-2], got[W-3], got[CW-1:0], exp[W-1], exp[W-2], exp[W-3], exp[CW-1:0]);
    end
  endtask

  function automatic logic [W-1:0] pack(input int v, input int c, input int b, input int cr);
    logic [W-1:0] r;
    r = {v[0], c[0], b[0], cr[CW-1:0]};
    return r;
  endfunction

  // driver: present one coin/cancel for one cycle and push the expected response
  task automatic cycle(input logic [1:0] c, input logic can);
    int sum;
    @(posedge clk);
    #1;
    coin   = c;
    cancel = can;
    if (m_change > 0) begin
      exp_q.push_back(pack(0, 1, 1, m_change));
      m_change--;
    end else begin
      sum = m_credit + coin_units(c);
      exp_q.push_back(pack(sum >= PRICE, 0, 0, m_credit));
      if (sum >= PRICE) begin
        m_change = sum - PRICE;
        m_credit = 0;
      end else if (CANCEL_EN && can && sum > 0) begin
        m_change = sum;
        m_credit = 0;
      end else begin
        m_credit = sum;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(2'b00, 1'b0);
  endtask

  // monitor: compare DUT outputs mid-cycle against the oldest expectation
  always @(negedge clk) begin
    if (mon_en && exp_q.size() > 0) check("cycle", {vend, chg5, busy, credit}, exp_q.pop_front());
  end

  initial begin
    clk_en = 1'b0;
    reset  = 1'b1;
    coin   = 2'b00;
    cancel = 1'b0;
    #3 reset = 1'b0;
    #2 check("reset_no_clock", {vend, chg5, busy, credit}, '0);
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b1;

    cycle(2'b10, 1'b0); cycle(2'b10, 1'b0); idle(2);
    cycle(2'b01, 1'b0); cycle(2'b01, 1'b0); cycle(2'b01, 1'b0); cycle(2'b10, 1'b0); idle(3);
    cycle(2'b10, 1'b0); cycle(2'b11, 1'b0); cycle(2'b01, 1'b0); idle(5);

    // reset in the middle of change payout
    cycle(2'b10, 1'b0); cycle(2'b11, 1'b0); cycle(2'b00, 1'b0);
    @(negedge clk); #1;
    mon_en = 1'b0;
    exp_q.delete();
    reset = 1'b0;
    #1 check("reset_mid_change", {vend, chg5, busy, credit}, '0);
    coin = 2'b01;
    #1 check("reset_hold_coin", {vend, chg5, busy, credit}, '0);
    coin = 2'b00;
    @(negedge clk);
    reset    = 1'b1;
    m_credit = 0;
    m_change = 0;
    mon_en   = 1'b1;
    idle(4);

    // refund request with 3 units banked
    cycle(2'b01, 1'b0); cycle(2'b10, 1'b0); cycle(2'b00, 1'b1); idle(5);

    for (int i = 0; i < 400; i++)
      cycle(2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
    idle(6);

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
